sha256_w_stream_reader: RTL and testbench

Serial read-out end of the SHA-256 message schedule. Accepts one 512-bit message block, then streams the 64 schedule words W[0..63] one per handshake to the compression datapath over a valid/ready interface. Expansion for t ≥ 16 is computed on the fly from a 16-word sliding window. This is the streaming counterpart to the parallel pipelined W-memory stages, for the sequential/area-optimised core path.

---
 rtl/sha256_w_stream_reader.sv | 80 ++++++++
 tb/tb_sha256_w_stream_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message schedule, serial form: loads one 512-bit block and streams
// W[0..63] over valid/ready, expanding W[t+16] from a 16-word sliding window.
module sha256_w_stream_reader (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  idx;
  logic [31:0] nw;
  logic        fire;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  always_comb begin
    nw = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  end

  assign fire    = (state == RUN) && w_ready;
  assign w_out   = win[0];
  assign w_idx   = idx;
  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 16; i++) win[i] <= block_in[32*(15-i) +: 32];
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (idx == 6'd63) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              // Past t = 48 the shifted-in words are never presented; harmless.
              for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
              win[15] <= nw;
              idx     <= idx + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Bench for sha256_w_stream_reader: array-level schedule model plus a
// per-cycle compare process; directed streams with stalls, start pokes, reset.
module tb_sha256_w_stream_reader;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         busy;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         done;

  sha256_w_stream_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
    .w_out(w_out), .w_idx(w_idx), .done(done)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  // Expected schedule for the block currently being streamed
  logic [31:0] ew [64];
  bit          m_run = 1'b0;
  int unsigned m_t = 0;
  bit          m_done = 1'b0;
  bit          m_after_reset = 1'b0;
  bit          chk_en = 1'b0;
  int unsigned dut_hs = 0;

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ZERO = '0;
  localparam logic [511:0] INC  = {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                                   32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f,
                                   32'h20212223, 32'h24252627, 32'h28292a2b, 32'h2c2d2e2f,
                                   32'h30313233, 32'h34353637, 32'h38393a3b, 32'h3c3d3e3f};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) ew[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(ew[t-15], 7) ^ ror(ew[t-15], 18) ^ (ew[t-15] >> 3);
      s1 = ror(ew[t-2], 17) ^ ror(ew[t-2], 19) ^ (ew[t-2] >> 10);
      ew[t] = s1 + ew[t-7] + s0 + ew[t-16];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  // Compare at negedge, advance the model on the posedge from the inputs
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("done", {31'b0, done}, {31'b0, m_done});
        if (m_done) chk("handshakes", dut_hs, 64);
        if (m_run) begin
          chk("w_valid", {31'b0, w_valid}, 32'd1);
          chk("busy", {31'b0, busy}, 32'd1);
          chk("w_idx", {26'b0, w_idx}, m_t);
          chk("w_out", w_out, ew[m_t]);
        end else begin
          chk("w_valid_idle", {31'b0, w_valid}, 32'd0);
          chk("busy_idle", {31'b0, busy}, 32'd0);
          if (m_after_reset) begin
            chk("w_out_reset", w_out, 32'd0);
            chk("w_idx_reset", {26'b0, w_idx}, 32'd0);
          end
        end
      end
      @(posedge CLK);
      if (w_valid && w_ready) dut_hs++;
      if (!RST) begin
        chk_en = 1'b1;
        m_run = 1'b0; m_t = 0; m_done = 1'b0; m_after_reset = 1'b1; dut_hs = 0;
      end else begin
        m_done = 1'b0;
        if (m_run) begin
          if (w_ready) begin
            if (m_t == 63) begin m_run = 1'b0; m_done = 1'b1; end
            else m_t++;
          end
        end else if (start) begin
          expand(block_in);
          m_run = 1'b1; m_t = 0; m_after_reset = 1'b0; dut_hs = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic launch(input logic [511:0] blk);
    block_in = blk; start = 1'b1; w_ready = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs the consumer until done is seen; returns in the done cycle
  task automatic drain(input bit bp, input bit poke);
    bit hit = 1'b0;
    int unsigned s15 = 0, s63 = 0;
    for (int c = 0; c < 600 && !hit; c++) begin
      w_ready = 1'b1;
      if (bp) begin
        w_ready = 1'($urandom_range(0, 1));
        if (w_valid && w_idx == 6'd15 && s15 < 10) begin w_ready = 1'b0; s15++; end
        if (w_valid && w_idx == 6'd63 && s63 < 10) begin w_ready = 1'b0; s63++; end
      end
      if (poke && w_valid && (w_idx == 6'd5 || w_idx == 6'd40)) begin
        start = 1'b1; block_in = INC ^ {16{32'hdeadbeef}};
      end else start = 1'b0;
      tick();
      if (done) hit = 1'b1;
    end
    start = 1'b0;
    w_ready = 1'b1;
    if (!hit) begin
      vectors++; fails++;
      $display("FAIL drain_timeout: got no done expected done within 600 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with start asserted
    RST = 1'b0; start = 1'b1; block_in = ABC; w_ready = 1'b1;
    idle(3);
    #0;
    RST = 1'b1; start = 1'b0;
    idle(2);

    launch(ABC);
    drain(1'b0, 1'b0);
    chk("pin_w0", ew[0], 32'h61626380);
    chk("pin_w15", ew[15], 32'h00000018);
    chk("pin_w16", ew[16], 32'h61626380);
    chk("pin_w17", ew[17], 32'h000F0000);
    idle(2);

    launch(ZERO);
    drain(1'b0, 1'b0);
    chk("pin_zero_w63", ew[63], 32'h00000000);
    idle(2);

    launch(ABC);
    drain(1'b1, 1'b0);
    idle(2);

    launch(ABC);
    drain(1'b0, 1'b1);
    // Start in the done cycle chains straight into the next block
    launch(INC);
    chk("chain_w0", w_out, 32'h00010203);
    chk("chain_valid", {31'b0, w_valid}, 32'd1);
    drain(1'b0, 1'b0);
    idle(2);

    launch(INC);
    for (int c = 0; c < 100 && !(w_valid && w_idx == 6'd30); c++) tick();
    chk("reach_t30", {26'b0, w_idx}, 32'd30);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("abort_valid", {31'b0, w_valid}, 32'd0);
    idle(3);

    launch(ABC);
    drain(1'b0, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
